sdm_ni_tx: RTL

- Synchronous-to-asynchronous network-interface transmitter. Injects wormhole frames from a clocked local core into the local input port of an asynchronous SDM router.
- Encodes each flit onto 1-of-4 sub-channels (o0..o3 per digit) plus an end-of-frame wire (o4).
- Runs the 4-phase return-to-zero handshake against a single ack, which is synchronised into the clock domain.
- It is the sender for the router input buffer: the head flit carries the target x/y digits that the router's route decoder compares.

---
 rtl/sdm_ni_pkg.sv | 22 ++
 rtl/dr4_enc.sv | 24 ++
 rtl/sdm_ni_tx.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sdm_ni_pkg.sv
// Shared types and helpers for the SDM network-interface transmitter.
// Holds the FSM state type, head digit positions and the 1-of-4 digit encoder.
package sdm_ni_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RTZ  = 2'd2
    } state_t;

    localparam int X_LO     = 0;
    localparam int X_HI     = 1;
    localparam int Y_LO     = 2;
    localparam int Y_HI     = 3;
    localparam int AUX_BASE = 4;

    // Bit r of the result is the level of rail o<r> for digit value d.
    function automatic logic [3:0] enc_1of4(input logic [1:0] d);
        enc_1of4 = 4'(4'b0001 << d);
    endfunction

endpackage

// File: rtl/dr4_enc.sv
// Combinational 1-of-4 encoder: one 2-bit digit per sub-channel onto four rails.
// Digit j drives bit j of exactly one of r0..r3.
module dr4_enc
    import sdm_ni_pkg::*;
#(
    parameter int SCN = 8
) (
    input  logic [2*SCN-1:0] bin,
    output logic [SCN-1:0]   r0,
    output logic [SCN-1:0]   r1,
    output logic [SCN-1:0]   r2,
    output logic [SCN-1:0]   r3
);

    for (genvar j = 0; j < SCN; j++) begin : g_dig
        logic [3:0] code;
        assign code  = enc_1of4(bin[2*j +: 2]);
        assign r0[j] = code[0];
        assign r1[j] = code[1];
        assign r2[j] = code[2];
        assign r3[j] = code[3];
    end

endmodule

// File: rtl/sdm_ni_tx.sv
// Clocked-to-asynchronous NI transmitter: sends wormhole frames as 1-of-4 codewords
// with a 4-phase return-to-zero handshake against a synchronised ack.
//
// state | meaning
// IDLE  | no frame in progress; head accepted once the ack has returned to 0
// SEND  | codeword on the rails, waiting for ack_s to rise
// RTZ   | spacer on the rails, waiting for ack_s to fall, then next body flit or frame end
module sdm_ni_tx
    import sdm_ni_pkg::*;
#(
    parameter int DW   = 16,
    parameter int SCN  = DW / 2,
    parameter int SYNC = 2,
    parameter int CW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hdr_valid,
    output logic          hdr_ready,
    input  logic [3:0]    dst_x,
    input  logic [3:0]    dst_y,
    input  logic [DW-9:0] hdr_aux,
    input  logic          hdr_last,
    input  logic          dat_valid,
    output logic          dat_ready,
    input  logic [DW-1:0] dat,
    input  logic          dat_last,
    output logic [SCN-1:0] o0,
    output logic [SCN-1:0] o1,
    output logic [SCN-1:0] o2,
    output logic [SCN-1:0] o3,
    output logic          o4,
    input  logic          oa,
    output logic          busy,
    output logic [CW-1:0] frame_cnt,
    output logic [CW-1:0] flit_cnt
);

    state_t          state_q;
    state_t          state_d;
    logic [SYNC-1:0] sync_q;
    logic            ack_s;
    logic            live_q;
    logic            tail_q;
    logic            load_hdr;
    logic            load_dat;
    logic            to_spacer;
    logic            frame_inc;
    logic [DW-1:0]   hdr_bin;
    logic [DW-1:0]   enc_bin;
    logic [SCN-1:0]  r0;
    logic [SCN-1:0]  r1;
    logic [SCN-1:0]  r2;
    logic [SCN-1:0]  r3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], oa};
        end
    end

    assign ack_s = sync_q[SYNC-1];

    // live_q keeps hdr_ready low while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    always_comb begin
        hdr_bin = '0;
        hdr_bin[2*X_LO +: 2]         = dst_x[1:0];
        hdr_bin[2*X_HI +: 2]         = dst_x[3:2];
        hdr_bin[2*Y_LO +: 2]         = dst_y[1:0];
        hdr_bin[2*Y_HI +: 2]         = dst_y[3:2];
        hdr_bin[2*AUX_BASE +: DW-8]  = hdr_aux;
    end

    assign enc_bin = (state_q == IDLE) ? hdr_bin : dat;

    dr4_enc #(.SCN(SCN)) u_enc (
        .bin (enc_bin),
        .r0  (r0),
        .r1  (r1),
        .r2  (r2),
        .r3  (r3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hdr_ready = 1'b0;
        dat_ready = 1'b0;
        busy      = 1'b0;
        load_hdr  = 1'b0;
        load_dat  = 1'b0;
        to_spacer = 1'b0;
        frame_inc = 1'b0;
        case (state_q)
            IDLE: begin
                hdr_ready = live_q & ~ack_s;
                if (hdr_valid && live_q && !ack_s) begin
                    load_hdr = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                busy = 1'b1;
                if (ack_s) begin
                    to_spacer = 1'b1;
                    state_d   = RTZ;
                end
            end
            RTZ: begin
                busy = 1'b1;
                if (!ack_s) begin
                    if (tail_q) begin
                        frame_inc = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        dat_ready = 1'b1;
                        if (dat_valid) begin
                            load_dat = 1'b1;
                            state_d  = SEND;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Rails are pure flops so nothing combinational can glitch onto the wires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o0     <= '0;
            o1     <= '0;
            o2     <= '0;
            o3     <= '0;
            o4     <= 1'b0;
            tail_q <= 1'b0;
        end else if (load_hdr || load_dat) begin
            o0     <= r0;
            o1     <= r1;
            o2     <= r2;
            o3     <= r3;
            o4     <= load_hdr ? hdr_last : dat_last;
            tail_q <= load_hdr ? hdr_last : dat_last;
        end else if (to_spacer) begin
            o0 <= '0;
            o1 <= '0;
            o2 <= '0;
            o3 <= '0;
            o4 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            flit_cnt  <= '0;
        end else begin
            if (frame_inc) begin
                frame_cnt <= frame_cnt + CW'(1);
            end
            if (to_spacer) begin
                flit_cnt <= flit_cnt + CW'(1);
            end
        end
    end

endmodule
